// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder slice used by the serial adder datapath; purely combinational.
module fa_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: accepts two operands plus carry-in, adds LSB-first over
// WIDTH cycles through a single full-adder slice, then holds the result.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a new operation (start_ready=1)
// SHIFT | one operand bit pair per cycle through the adder slice
// DONE  | result held on sum/cout until consumer takes it
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_shifted;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;

    fa_bit u_fa (
        .x  (op_a[0]),
        .y  (op_b[0]),
        .ci (carry_q),
        .s  (fa_sum),
        .co (fa_carry)
    );

    // Result fills from the top so after WIDTH shifts bit 0 lands at bit 0;
    // written this way so WIDTH=1 needs no special case.
    always_comb begin
        res_shifted = res_q >> 1;
        res_shifted[WIDTH-1] = fa_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        op_a        <= a;
                        op_b        <= b;
                        carry_q     <= cin;
                        res_q       <= '0;
                        cnt         <= '0;
                        state       <= SHIFT;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                SHIFT: begin
                    op_a    <= op_a >> 1;
                    op_b    <= op_b >> 1;
                    carry_q <= fa_carry;
                    res_q   <= res_shifted;
                    // Final increment reaches WIDTH, which still fits in CW bits.
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state       <= IDLE;
                        res_valid   <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                    res_valid   <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    assign sum  = res_q;
    assign cout = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: vector table at WIDTH=8 plus
// hand-written handshake, reset and WIDTH=1 sequences.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid, start_ready, cin, res_valid, res_ready, cout, busy;
    logic [7:0] a, b, sum;

    logic       sv1, sr1, a1, b1, cin1, rv1, rr1, sum1, cout1, busy1;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .cin(cin),
        .res_valid(res_valid), .res_ready(res_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .start_valid(sv1), .start_ready(sr1),
        .a(a1), .b(b1), .cin(cin1),
        .res_valid(rv1), .res_ready(rr1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[10];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Called at a sampling point (#1 after an edge); returns #1 after the accepting edge.
    task automatic start8(input logic [7:0] aa, input logic [7:0] bb, input logic c);
        check("start_ready_idle", start_ready, 1);
        a = aa; b = bb; cin = c; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain8();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("drain_start_ready", start_ready, 1);
        check("drain_res_valid", res_valid, 0);
        check("drain_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[9] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};

        rst = 1'b1;
        start_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        sv1 = 1'b0; rr1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_ready", start_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_w1_start_ready", sr1, 1);
        check("rst_w1_sum", sum1, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            start8(vecs[i].a, vecs[i].b, vecs[i].cin);
            check("vec_busy_shift", busy, 1);
            check("vec_valid_shift", res_valid, 0);
            wait_done8(lat);
            check("vec_latency", lat, 8);
            check("vec_sum", sum, vecs[i].sum);
            check("vec_cout", cout, vecs[i].cout);
            drain8();
        end

        // Backpressure: result must hold while res_ready stays low.
        start8(8'hC3, 8'h4E, 1'b0);
        wait_done8(lat);
        check("bp_latency", lat, 8);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_sum", sum, 8'h11);
            check("bp_cout", cout, 1);
            check("bp_res_valid", res_valid, 1);
            check("bp_start_ready", start_ready, 0);
        end
        drain8();

        // Reset in the third SHIFT cycle aborts the operation.
        start8(8'hFF, 8'h01, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_start_ready", start_ready, 1);
        check("abort_res_valid", res_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        start8(8'h10, 8'h20, 1'b0);
        wait_done8(lat);
        check("after_abort_latency", lat, 8);
        check("after_abort_sum", sum, 8'h30);
        check("after_abort_cout", cout, 0);
        drain8();

        // Inputs churning during SHIFT must not disturb the accepted operands.
        start8(8'h5A, 8'h3C, 1'b1);
        lat = 0;
        while (!res_valid && lat < 40) begin
            a = 8'($urandom); b = 8'($urandom); cin = ~cin;
            start_valid = ~start_valid;
            check("churn_start_ready", start_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        check("churn_latency", lat, 8);
        check("churn_sum", sum, 8'h97);
        check("churn_cout", cout, 0);

        // start_valid held through the drain: one IDLE cycle precedes the next op.
        a = 8'h01; b = 8'h02; cin = 1'b0; start_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("gap_busy", busy, 0);
        check("gap_start_ready", start_ready, 1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        check("gap_accept_busy", busy, 1);
        wait_done8(lat);
        check("gap_latency", lat, 8);
        check("gap_sum", sum, 8'h03);
        drain8();

        // Reset beats the res_ready handshake.
        start8(8'hFF, 8'hFF, 1'b1);
        wait_done8(lat);
        res_ready = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0; rst = 1'b0;
        check("rst_done_sum", sum, 0);
        check("rst_done_cout", cout, 0);
        check("rst_done_valid", res_valid, 0);
        check("rst_done_ready", start_ready, 1);

        // Reset beats acceptance.
        start_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0; rst = 1'b0;
        check("rst_accept_busy", busy, 0);
        check("rst_accept_ready", start_ready, 1);

        // WIDTH=1: exactly one SHIFT cycle.
        check("w1_ready", sr1, 1);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; sv1 = 1'b1;
        @(posedge clk); #1;
        sv1 = 1'b0;
        check("w1_busy", busy1, 1);
        check("w1_valid_shift", rv1, 0);
        @(posedge clk); #1;
        check("w1_valid", rv1, 1);
        check("w1_sum", sum1, 1);
        check("w1_cout", cout1, 1);
        rr1 = 1'b1;
        @(posedge clk); #1;
        rr1 = 1'b0;
        check("w1_drain_valid", rv1, 0);
        check("w1_drain_ready", sr1, 1);

        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; sv1 = 1'b1;
        @(posedge clk); #1;
        sv1 = 1'b0;
        @(posedge clk); #1;
        check("w1b_valid", rv1, 1);
        check("w1b_sum", sum1, 1);
        check("w1b_cout", cout1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
